// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, two byte-enabled write ports (B wins on overlap).
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic [DATA_W/8-1:0]      wa_be,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [DATA_W/8-1:0]      wb_be,
    output logic                     collide,
    output logic [ADDR_W-1:0]        collide_addr
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NBYTE = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              hit;

    assign hit = wa_en && wb_en && (wa_addr == wb_addr);

    // Word as it will look after this edge: port A bytes first, then port B overrides.
    function automatic logic [DATA_W-1:0] merge_word(input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] base);
        logic [DATA_W-1:0] word;
        word = base;
        for (int k = 0; k < NBYTE; k++) begin
            if (wa_en && wa_addr == addr && wa_be[k]) word[k*8 +: 8] = wa_data[k*8 +: 8];
        end
        for (int k = 0; k < NBYTE; k++) begin
            if (wb_en && wb_addr == addr && wb_be[k]) word[k*8 +: 8] = wb_data[k*8 +: 8];
        end
        return word;
    endfunction

    // NOTE: the array is reset like any other flop because reset must read back zero on every address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
        end else begin
            for (int w = 0; w < DEPTH; w++) begin
                // NOTE: non-blocking so every word samples the pre-edge contents.
                if (ZERO_REG == 0 || w != 0) mem[w] <= merge_word(ADDR_W'(w), mem[w]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            collide      <= 1'b0;
            collide_addr <= '0;
        end else begin
            collide <= hit;
            if (hit) collide_addr <= wa_addr;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rw;
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            rw = mem[ra];
`ifdef REGFILE_BYPASS_EN
            rw = merge_word(ra, rw);
`else
            rw = rw;
`endif
            if (ZERO_REG != 0 && ra == '0) rw = '0;
            rd_data[i*DATA_W +: DATA_W] = rw;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table with scoreboard queue plus reset and bypass sequences.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data, rd_data_z;
    logic              wa_en, wb_en;
    logic [AW-1:0]     wa_addr, wb_addr;
    logic [DW-1:0]     wa_data, wb_data;
    logic [3:0]        wa_be, wb_be;
    logic              collide, collide_z;
    logic [AW-1:0]     collide_addr, collide_addr_z;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_be(wa_be),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
        .collide(collide), .collide_addr(collide_addr)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(0)) dut_z (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_z),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_be(wa_be),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
        .collide(collide_z), .collide_addr(collide_addr_z)
    );

    typedef struct {
        logic          wa_en;
        logic [AW-1:0] wa_addr;
        logic [DW-1:0] wa_data;
        logic [3:0]    wa_be;
        logic          wb_en;
        logic [AW-1:0] wb_addr;
        logic [DW-1:0] wb_data;
        logic [3:0]    wb_be;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] exp0, exp1, exp0_z;
        logic          exp_col;
        logic [AW-1:0] exp_caddr;
    } tv_t;

    tv_t vec [13];
    tv_t sb_q [$];
    int  checks = 0;
    int  failures = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_writes();
        wa_en = 1'b0; wa_addr = '0; wa_data = '0; wa_be = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_be = '0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        //          waen waddr wadata        wabe     wben wbaddr wbdata       wbbe     ra0 ra1 exp0          exp1          exp0_z        col caddr
        vec[0]  = '{1'b1, 5'd2,  32'h00000003, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd2, 5'd0, 32'h00000003, 32'h0,        32'h00000003, 1'b0, 5'd0};
        vec[1]  = '{1'b1, 5'd2,  32'h00000006, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd2, 5'd0, 32'h00000006, 32'h0,        32'h00000006, 1'b0, 5'd0};
        vec[2]  = '{1'b1, 5'd7,  32'hAABBCCDD, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd7, 5'd2, 32'hAABBCCDD, 32'h00000006, 32'hAABBCCDD, 1'b0, 5'd0};
        vec[3]  = '{1'b1, 5'd7,  32'h11223344, 4'h5, 1'b0, 5'd0,  32'h0,        4'h0, 5'd7, 5'd2, 32'hAA22CC44, 32'h00000006, 32'hAA22CC44, 1'b0, 5'd0};
        vec[4]  = '{1'b1, 5'd9,  32'h000000FF, 4'h3, 1'b1, 5'd9,  32'hFFFF0000, 4'h6, 5'd9, 5'd7, 32'h00FF00FF, 32'hAA22CC44, 32'h00FF00FF, 1'b1, 5'd9};
        vec[5]  = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        4'h0, 5'd9, 5'd0, 32'h00FF00FF, 32'h0,        32'h00FF00FF, 1'b0, 5'd9};
        vec[6]  = '{1'b1, 5'd10, 32'h11111111, 4'hF, 1'b1, 5'd11, 32'h22222222, 4'hF, 5'd10, 5'd11, 32'h11111111, 32'h22222222, 32'h11111111, 1'b0, 5'd9};
        vec[7]  = '{1'b1, 5'd10, 32'hFFFFFFFF, 4'h0, 1'b0, 5'd10, 32'hEEEEEEEE, 4'hF, 5'd10, 5'd11, 32'h11111111, 32'h22222222, 32'h11111111, 1'b0, 5'd9};
        vec[8]  = '{1'b1, 5'd12, 32'hAAAAAAAA, 4'hF, 1'b1, 5'd12, 32'hBBBBBBBB, 4'hF, 5'd12, 5'd10, 32'hBBBBBBBB, 32'h11111111, 32'hBBBBBBBB, 1'b1, 5'd12};
        vec[9]  = '{1'b1, 5'd13, 32'h12000000, 4'h8, 1'b1, 5'd13, 32'h00000034, 4'h1, 5'd13, 5'd12, 32'h12000034, 32'hBBBBBBBB, 32'h12000034, 1'b1, 5'd13};
        vec[10] = '{1'b1, 5'd0,  32'hDEADBEEF, 4'hF, 1'b0, 5'd0,  32'h0,        4'h0, 5'd0, 5'd13, 32'h0,        32'h12000034, 32'hDEADBEEF, 1'b0, 5'd13};
        vec[11] = '{1'b1, 5'd0,  32'hDEADBEEF, 4'hF, 1'b1, 5'd0,  32'h00000077, 4'h1, 5'd0, 5'd13, 32'h0,        32'h12000034, 32'hDEADBE77, 1'b1, 5'd0};
        vec[12] = '{1'b0, 5'd0,  32'h0,        4'h0, 1'b0, 5'd0,  32'h0,        4'h0, 5'd13, 5'd12, 32'h12000034, 32'hBBBBBBBB, 32'h12000034, 1'b0, 5'd0};

        // Reset state
        rst = 1'b0;
        idle_writes();
        set_rd(5'd0, 5'd5);
        #2;
        check("reset_rd0", rd_data[0 +: DW], 32'h0);
        check("reset_rd1", rd_data[DW +: DW], 32'h0);
        check("reset_collide", {31'b0, collide}, 32'h0);
        check("reset_caddr", {27'b0, collide_addr}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            tv_t e;
            @(negedge clk);
            wa_en = vec[i].wa_en; wa_addr = vec[i].wa_addr; wa_data = vec[i].wa_data; wa_be = vec[i].wa_be;
            wb_en = vec[i].wb_en; wb_addr = vec[i].wb_addr; wb_data = vec[i].wb_data; wb_be = vec[i].wb_be;
            sb_q.push_back(vec[i]);
            @(posedge clk);
            #1;
            idle_writes();
            set_rd(vec[i].ra0, vec[i].ra1);
            #1;
            e = sb_q.pop_front();
            check($sformatf("v%0d_rd0", i), rd_data[0 +: DW], e.exp0);
            check($sformatf("v%0d_rd1", i), rd_data[DW +: DW], e.exp1);
            check($sformatf("v%0d_rd0_nozero", i), rd_data_z[0 +: DW], e.exp0_z);
            check($sformatf("v%0d_collide", i), {31'b0, collide}, {31'b0, e.exp_col});
            check($sformatf("v%0d_caddr", i), {27'b0, collide_addr}, {27'b0, e.exp_caddr});
        end

        // Read during write to r4: forwarded only when the bypass is built in
        @(negedge clk);
        wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h00000055; wa_be = 4'hF;
        set_rd(5'd4, 5'd0);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_pre_edge", rd_data[0 +: DW], 32'h00000055);
`else
        check("nobypass_pre_edge", rd_data[0 +: DW], 32'h0);
`endif
        check("zero_reg_during_write", rd_data[DW +: DW], 32'h0);
        @(posedge clk);
        #1;
        idle_writes();
        #1;
        check("rdw_post_edge", rd_data[0 +: DW], 32'h00000055);

        // Colliding write to r5, then an asynchronous reset in mid-cycle
        @(negedge clk);
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'h12345678; wa_be = 4'hF;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hFFFFFFFF; wb_be = 4'h0;
        @(posedge clk);
        #1;
        idle_writes();
        set_rd(5'd5, 5'd4);
        #1;
        check("r5_written", rd_data[0 +: DW], 32'h12345678);
        check("r5_collide", {31'b0, collide}, 32'h1);
        check("r5_caddr", {27'b0, collide_addr}, 32'd5);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_r5", rd_data[0 +: DW], 32'h0);
        check("async_rst_r4", rd_data[DW +: DW], 32'h0);
        check("async_rst_r5_nozero", rd_data_z[0 +: DW], 32'h0);
        check("async_rst_collide", {31'b0, collide}, 32'h0);
        check("async_rst_caddr", {27'b0, collide_addr}, 32'h0);
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hCAFEF00D; wa_be = 4'hF;
        @(posedge clk);
        #1;
        check("write_in_reset", rd_data[0 +: DW], 32'h0);
        idle_writes();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("after_release", rd_data[0 +: DW], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
